// File: rtl/led_ring_pkg.sv
// Shared types and helpers for the LED ring monitor and its decoder.
package led_ring_pkg;

  // Sweep state; the encoding is exactly what appears on the dir output.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FILL   = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_RESYNC = 2'b11
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

  // Bits needed to hold a lit-LED count from 0 up to width inclusive.
  function automatic int lvl_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/led_thermo_decode.sv
// Combinational thermometer decoder: flags whether the word is a legal
// fill pattern (bits [k-1:0] set, rest clear) and reports the lit count.
module led_thermo_decode
  import led_ring_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LVL_W = lvl_w(WIDTH)
) (
  input  logic [WIDTH-1:0] led_q,
  output logic             valid,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] w_plus1;

  // A thermometer word plus one carries through every set bit, so the AND
  // of the two is zero; this also holds for all-zeros and all-ones.
  assign w_plus1 = led_q + WIDTH'(1);
  assign valid   = ((led_q & w_plus1) == '0);

  // Population count; equals k for any valid word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    level = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level = level + LVL_W'(led_q[i]);
    end
  end

endmodule

// File: rtl/led_ring_monitor.sv
// Passive observer for the LED ring bus: decodes the registered LED word
// into a fill level and sweep direction, counts completed laps, and flags
// malformed patterns (sticky) and stalled sweeps.
module led_ring_monitor
  import led_ring_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int HOLD_MAX = 1023,
  parameter int LAP_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [WIDTH-1:0]        led,
  input  logic                    err_clear,
  output logic [lvl_w(WIDTH)-1:0] level,
  output logic [1:0]              dir,
  output logic [LAP_W-1:0]        lap_count,
  output logic                    pattern_err,
  output logic                    stall
);

  localparam int LVL_W = lvl_w(WIDTH);
  localparam int CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(WIDTH);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

  // Registered state
  logic [WIDTH-1:0] r_led_q;
  logic [LVL_W-1:0] r_level;
  state_t           r_state;
  logic [LAP_W-1:0] r_lap;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;

  // Decode and next-state signals
  logic             w_valid;
  logic [LVL_W-1:0] w_dec_level;
  logic signed [LVL_W:0] w_delta;
  logic             w_change;
  logic             w_up;
  logic             w_dn;
  logic             w_jump;
  logic             w_err_ev;
  logic             w_lap_inc;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  led_thermo_decode #(
    .WIDTH (WIDTH),
    .LVL_W (LVL_W)
  ) u_decode (
    .led_q (r_led_q),
    .valid (w_valid),
    .level (w_dec_level)
  );

  // Level step with one extra sign bit so a drop cannot wrap into a rise.
  assign w_delta  = $signed({1'b0, w_dec_level}) - $signed({1'b0, r_level});
  assign w_change = w_valid && (w_dec_level != r_level);
  assign w_up     = (w_delta == $signed({{LVL_W{1'b0}}, 1'b1}));
  assign w_dn     = (w_delta == '1);
  assign w_jump   = w_change && !w_up && !w_dn;

  // Input stage: every decision is taken on the registered copy of led.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_led_q <= '0;
    end else if (enable) begin
      r_led_q <= led;
    end
  end

  // Sweep FSM next-state, error detection and lap event.
  always_comb begin
    w_state_nxt = r_state;
    w_err_ev    = 1'b0;
    w_lap_inc   = 1'b0;
    unique case (r_state)
      ST_RESYNC: begin
        // Errors are ignored here. Any valid empty word re-arms the
        // monitor, even when the level already reads 0, so a ring that
        // faulted while empty is not stranded in RESYNC.
        if (w_valid && (w_dec_level == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!w_valid || w_jump) begin
          w_err_ev = 1'b1;
        end else if (w_up) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!w_valid || w_jump) begin
          w_err_ev = 1'b1;
        end else if (w_dn) begin
          // Draining may only start from a completely lit ring.
          if (r_level == FULL_LEVEL) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_err_ev = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_valid || w_jump || w_up) begin
          w_err_ev = 1'b1;
        end else if (w_dn && (w_dec_level == '0)) begin
          w_state_nxt = ST_IDLE;
          w_lap_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RESYNC;
      end
    endcase
    if (w_err_ev) begin
      w_state_nxt = ST_RESYNC;
    end
  end

  // State, level and lap registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_lap   <= '0;
    end else if (enable) begin
      r_state <= w_state_nxt;
      if (w_valid) begin
        r_level <= w_dec_level;
      end
      if (w_lap_inc) begin
        r_lap <= r_lap + LAP_W'(1);
      end
    end
  end

  // Sticky error flag; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (enable) begin
      if (w_err_ev) begin
        r_err <= 1'b1;
      end else if (err_clear) begin
        r_err <= 1'b0;
      end
    end
  end

  // Stall counter next value: counts unchanged cycles mid-sweep, saturating.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_change || w_err_ev || (r_state == ST_IDLE) || (r_state == ST_RESYNC)) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != HOLD_LIMIT) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Stall counter and its registered limit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else if (enable) begin
      r_cnt   <= w_cnt_nxt;
      r_stall <= (w_cnt_nxt == HOLD_LIMIT);
    end
  end

  assign level       = r_level;
  assign dir         = r_state;
  assign lap_count   = r_lap;
  assign pattern_err = r_err;
  assign stall       = r_stall;

endmodule

// File: tb/tb_led_ring_monitor.sv
// Self-checking bench for led_ring_monitor: directed scenarios followed by
// a randomized sweep, all compared against a rule-level reference model.
module tb_led_ring_monitor;

  localparam int WIDTH    = 16;
  localparam int HOLD_MAX = 8;
  localparam int LAP_W    = 2;

  localparam int M_IDLE   = 0;
  localparam int M_FILL   = 1;
  localparam int M_DRAIN  = 2;
  localparam int M_RESYNC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        err_clear = 1'b0;
  logic [15:0] led = '0;
  logic [4:0]  level;
  logic [1:0]  dir;
  logic [1:0]  lap_count;
  logic        pattern_err;
  logic        stall;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] m_led_q;
  int          m_level;
  int          m_mode;
  int          m_lap;
  int          m_since;
  bit          m_err;
  bit          m_stall;

  always #5 clk = ~clk;

  led_ring_monitor #(
    .WIDTH    (WIDTH),
    .HOLD_MAX (HOLD_MAX),
    .LAP_W    (LAP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .led         (led),
    .err_clear   (err_clear),
    .level       (level),
    .dir         (dir),
    .lap_count   (lap_count),
    .pattern_err (pattern_err),
    .stall       (stall)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] word_of(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[15:0];
  endfunction

  function automatic bit thermo(input logic [15:0] w, output int k);
    k = 0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (w === word_of(i)) begin
        k = i;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_led_q = '0;
    m_level = 0;
    m_mode  = M_IDLE;
    m_lap   = 0;
    m_since = 0;
    m_err   = 1'b0;
    m_stall = 1'b0;
  endtask

  // One rising edge of the reference: rules applied to the previously
  // sampled word, then the current led is sampled.
  task automatic model_edge();
    int k;
    int d;
    int nxt;
    bit ok;
    bit chg;
    bit err_ev;
    if (!rst_n || !enable) return;
    ok     = thermo(m_led_q, k);
    chg    = ok && (k != m_level);
    d      = k - m_level;
    err_ev = 1'b0;
    nxt    = m_mode;
    if (m_mode == M_RESYNC) begin
      if (ok && k == 0) nxt = M_IDLE;
    end else if (!ok) begin
      err_ev = 1'b1;
    end else if (chg) begin
      if (d > 1 || d < -1) err_ev = 1'b1;
      else if (m_mode == M_IDLE) nxt = M_FILL;
      else if (m_mode == M_FILL && d == -1) begin
        if (m_level == WIDTH) nxt = M_DRAIN;
        else err_ev = 1'b1;
      end else if (m_mode == M_DRAIN && d == 1) err_ev = 1'b1;
      else if (m_mode == M_DRAIN && k == 0) begin
        nxt   = M_IDLE;
        m_lap = (m_lap + 1) % (1 << LAP_W);
      end
    end
    if (err_ev) nxt = M_RESYNC;
    if (ok) m_level = k;
    if (err_ev) m_err = 1'b1;
    else if (err_clear) m_err = 1'b0;
    if (chg || err_ev) m_since = 0;
    else m_since++;
    m_mode  = nxt;
    m_stall = (m_mode == M_FILL || m_mode == M_DRAIN) && (m_since >= HOLD_MAX);
    m_led_q = led;
  endtask

  task automatic check_outputs();
    check("level", level, m_level);
    check("dir", dir, m_mode);
    check("lap_count", lap_count, m_lap);
    check("pattern_err", pattern_err, m_err);
    check("stall", stall, m_stall);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive_hold(input int k, input int n);
    led = word_of(k);
    repeat (n) tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_level"}, level, 0);
    check({tag, "_dir"}, dir, 0);
    check({tag, "_lap"}, lap_count, 0);
    check({tag, "_err"}, pattern_err, 0);
    check({tag, "_stall"}, stall, 0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    int r;
    int cur;
    int wdir;
    int pause;

    // Reset state
    model_reset();
    #2;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Clean lap, one step per 4 cycles
    for (int k = 0; k < WIDTH; k++) drive_hold(k, 4);
    led = word_of(WIDTH);
    tick();
    check("peak_edge1", level, 15);
    tick();
    check("peak_edge2", level, 16);
    check("fill_dir", dir, 2'b01);
    tick();
    tick();
    led = word_of(WIDTH - 1);
    tick();
    tick();
    check("drain_dir", dir, 2'b10);
    tick();
    tick();
    for (int k = WIDTH - 2; k >= 0; k--) drive_hold(k, 4);
    check("lap_done", lap_count, 1);
    check("lap_err", pattern_err, 0);
    check("lap_idle", dir, 2'b00);

    // Invalid word mid-fill
    for (int k = 1; k <= 3; k++) drive_hold(k, 2);
    led = 16'h0005;
    tick();
    tick();
    check("invalid_err", pattern_err, 1);
    check("invalid_dir", dir, 2'b11);
    drive_hold(0, 3);
    check("resync_idle", dir, 2'b00);
    check("resync_lap", lap_count, 1);
    pulse_clear();
    check("clear_err", pattern_err, 0);

    // Skip 0x0003 -> 0x000F
    drive_hold(1, 2);
    drive_hold(2, 2);
    drive_hold(4, 2);
    check("skip_err", pattern_err, 1);
    check("skip_dir", dir, 2'b11);
    drive_hold(0, 3);
    pulse_clear();

    // Reversal below full
    for (int k = 1; k <= 5; k++) drive_hold(k, 2);
    drive_hold(4, 2);
    check("reverse_err", pattern_err, 1);
    check("reverse_dir", dir, 2'b11);
    drive_hold(0, 3);
    pulse_clear();

    // Stall while holding 0x00FF in FILL
    for (int k = 1; k <= 7; k++) drive_hold(k, 2);
    led = word_of(8);
    tick();
    tick();
    for (int i = 1; i <= HOLD_MAX; i++) begin
      tick();
      check($sformatf("stall_after_%0d", i), stall, (i == HOLD_MAX) ? 1 : 0);
    end
    tick();
    tick();
    led = word_of(9);
    tick();
    check("stall_held", stall, 1);
    tick();
    check("stall_fall", stall, 0);
    check("stall_level", level, 9);

    // Clear racing a new error: error wins
    led = 16'h0005;
    tick();
    tick();
    drive_hold(0, 3);
    check("race_pre_err", pattern_err, 1);
    check("race_pre_idle", dir, 2'b00);
    led = 16'h0005;
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("race_err", pattern_err, 1);
    check("race_dir", dir, 2'b11);
    drive_hold(0, 3);
    pulse_clear();

    // Lap counter wrap from a fresh reset
    rst_n = 1'b0;
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int lap = 1; lap <= 4; lap++) begin
      for (int k = 1; k <= WIDTH; k++) drive_hold(k, 1);
      for (int k = WIDTH - 1; k >= 0; k--) drive_hold(k, 1);
      tick();
      tick();
      check($sformatf("wrap_lap%0d", lap), lap_count, lap % 4);
    end

    // Asynchronous reset mid-drain
    for (int k = 1; k <= WIDTH; k++) drive_hold(k, 1);
    for (int k = WIDTH - 1; k >= 8; k--) drive_hold(k, 1);
    check("pre_reset_drain", dir, 2'b10);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    tick();
    rst_n = 1'b1;

    // Enable low freezes everything, including the input sample
    for (int k = 1; k <= 4; k++) drive_hold(k, 2);
    enable = 1'b0;
    repeat (10) begin
      led       = 16'($urandom);
      err_clear = 1'($urandom);
      tick();
      check("frozen_level", level, 4);
      check("frozen_dir", dir, 2'b01);
    end
    err_clear = 1'b0;
    enable    = 1'b1;
    led       = word_of(5);
    tick();
    tick();
    check("reenable_level", level, 5);

    // Randomized sweep against the model
    cur  = 5;
    wdir = 1;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 60) cur += wdir;
      else if (r < 72) begin
      end else if (r < 82) cur += ($urandom_range(0, 1) != 0) ? 1 : -1;
      else if (r < 88) cur = $urandom_range(0, WIDTH);
      else if (r < 92) begin
        pause = $urandom_range(5, 12);
        repeat (pause) tick();
      end
      if (cur >= WIDTH) begin
        cur  = WIDTH;
        wdir = -1;
      end
      if (cur <= 0) begin
        cur  = 0;
        wdir = 1;
      end
      if (r >= 97) led = 16'($urandom);
      else led = word_of(cur);
      err_clear = ($urandom_range(0, 19) == 0);
      enable    = ($urandom_range(0, 19) != 0);
      tick();
    end
    enable    = 1'b1;
    err_clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
